// File: rtl/rp_8bit_trace.sv
// Instruction-trace collector for the rp_8bit fetch stream: pairs two-word
// instructions into single records, classifies them and queues them in a FWFT FIFO.
module rp_8bit_trace #(
  parameter int PAW   = 16,
  parameter int DEPTH = 16,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_vld,
  input  logic [PAW-1:0]             if_adr,
  input  logic [15:0]                if_ins,
  input  logic                       if_flush,
  output logic                       tr_vld,
  input  logic                       tr_rdy,
  output logic [PAW-1:0]             tr_adr,
  output logic [15:0]                tr_ins,
  output logic [15:0]                tr_ext,
  output logic                       tr_len,
  output logic [2:0]                 tr_cls,
  output logic                       tr_err,
  output logic [$clog2(DEPTH):0]     tr_cnt,
  output logic [CW-1:0]              tr_drp
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PAW-1:0] adr;
    logic [15:0]    ins;
    logic [15:0]    ext;
    logic           len;
    logic [2:0]     cls;
    logic           err;
  } rec_t;

  typedef enum logic {IDLE, WAIT2} state_t;

  // lds / sts / jmp / call carry a second operand word
  function automatic logic two_word(input logic [15:0] w);
    logic r;
    r = 1'b0;
    casez (w)
      16'b1001_000?_????_0000,
      16'b1001_001?_????_0000,
      16'b1001_010?_????_11??: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] op_class(input logic [15:0] w);
    logic [2:0] c;
    c = 3'd0;
    casez (w)
      16'b1100_????_????_????, 16'b1101_????_????_????,
      16'b1001_010?_????_11??, 16'b1111_0???_????_????,
      16'h9409, 16'h9419, 16'h9509, 16'h9519,
      16'h9508, 16'h9518:                               c = 3'd1;
      16'b0001_00??_????_????, 16'b1001_1001_????_????,
      16'b1001_1011_????_????, 16'b1111_11??_????_0???: c = 3'd2;
      16'b10?0_??0?_????_????, 16'b1011_0???_????_????,
      16'h95C8, 16'h95D8,
      16'b1001_000?_????_0000, 16'b1001_000?_????_0001,
      16'b1001_000?_????_0010, 16'b1001_000?_????_01??,
      16'b1001_000?_????_1001, 16'b1001_000?_????_1010,
      16'b1001_000?_????_11??:                          c = 3'd3;
      16'b10?0_??1?_????_????, 16'b1011_1???_????_????,
      16'b1001_001?_????_0000, 16'b1001_001?_????_0001,
      16'b1001_001?_????_0010, 16'b1001_001?_????_1001,
      16'b1001_001?_????_1010, 16'b1001_001?_????_11??: c = 3'd4;
      default: c = (w[15:8] == 8'h00 && w[7:0] != 8'h00) ? 3'd5 : 3'd0;
    endcase
    return c;
  endfunction

  state_t         state_q, state_d;
  logic [PAW-1:0] pend_adr_q;
  logic [15:0]    pend_ins_q;
  logic [PAW-1:0] pend_nxt;
  logic           latch, push;
  rec_t           push_rec;

  assign pend_nxt = pend_adr_q + PAW'(1);

  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    push     = 1'b0;
    push_rec = '0;
    case (state_q)
      IDLE: begin
        if (if_vld) begin
          if (two_word(if_ins)) begin
            latch   = 1'b1;
            state_d = WAIT2;
          end else begin
            push         = 1'b1;
            push_rec.adr = if_adr;
            push_rec.ins = if_ins;
            push_rec.cls = op_class(if_ins);
          end
        end
      end
      WAIT2: begin
        // a flush abandons the half-built record; it is not a drop
        if (if_flush) begin
          state_d = IDLE;
        end else if (if_vld) begin
          push         = 1'b1;
          push_rec.adr = pend_adr_q;
          push_rec.ins = pend_ins_q;
          push_rec.ext = if_ins;
          push_rec.len = 1'b1;
          push_rec.cls = op_class(pend_ins_q);
          push_rec.err = (if_adr != pend_nxt);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_adr_q <= '0;
      pend_ins_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        pend_adr_q <= if_adr;
        pend_ins_q <= if_ins;
      end
    end
  end

  rec_t          mem [DEPTH];
  rec_t          hold_q, head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [CW-1:0] drp_q;
  logic          full, pop, wr_en;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign pop   = tr_vld & tr_rdy;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drp_q    <= '0;
      hold_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        hold_q   <= mem[rd_ptr_q];
      end
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop && drp_q != {CW{1'b1}})
        drp_q <= drp_q + CW'(1);
    end
  end

  // empty FIFO shows the last popped record so outputs never go stale-random
  assign tr_vld = (cnt_q != '0);
  assign head   = tr_vld ? mem[rd_ptr_q] : hold_q;
  assign tr_adr = head.adr;
  assign tr_ins = head.ins;
  assign tr_ext = head.ext;
  assign tr_len = head.len;
  assign tr_cls = head.cls;
  assign tr_err = head.err;
  assign tr_cnt = cnt_q;
  assign tr_drp = drp_q;

endmodule

// File: tb/tb_rp_8bit_trace.sv
// Directed + randomized bench for rp_8bit_trace against a queue-based record model.
module tb_rp_8bit_trace;
  localparam int PAW = 16, DEPTH = 16, CW = 8;
  localparam int DMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic if_vld = 0, if_flush = 0, tr_rdy = 0;
  logic [PAW-1:0] if_adr = '0;
  logic [15:0] if_ins = '0;
  logic tr_vld, tr_len, tr_err;
  logic [PAW-1:0] tr_adr;
  logic [15:0] tr_ins, tr_ext;
  logic [2:0] tr_cls;
  logic [$clog2(DEPTH):0] tr_cnt;
  logic [CW-1:0] tr_drp;

  rp_8bit_trace #(.PAW(PAW), .DEPTH(DEPTH), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .if_vld(if_vld), .if_adr(if_adr), .if_ins(if_ins),
    .if_flush(if_flush), .tr_vld(tr_vld), .tr_rdy(tr_rdy), .tr_adr(tr_adr),
    .tr_ins(tr_ins), .tr_ext(tr_ext), .tr_len(tr_len), .tr_cls(tr_cls),
    .tr_err(tr_err), .tr_cnt(tr_cnt), .tr_drp(tr_drp));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] adr, ins, ext;
    logic        len;
    logic [2:0]  cls;
    logic        err;
  } m_rec_t;

  int checks = 0, failures = 0;
  m_rec_t q[$];
  m_rec_t last;
  bit pend;
  logic [15:0] p_adr, p_ins;
  int drops;

  function automatic bit ref_two(input logic [15:0] w);
    return (w ==? 16'b1001_000?_????_0000) || (w ==? 16'b1001_001?_????_0000) ||
           (w ==? 16'b1001_010?_????_11??);
  endfunction

  function automatic logic [2:0] ref_cls(input logic [15:0] w);
    logic [3:0] n;
    n = w[3:0];
    if (w inside {16'h9409, 16'h9419, 16'h9509, 16'h9519, 16'h9508, 16'h9518} ||
        w[15:12] == 4'hC || w[15:12] == 4'hD || w[15:11] == 5'b11110 ||
        (w[15:9] == 7'b1001010 && w[3:2] == 2'b11)) return 3'd1;
    if (w[15:10] == 6'b000100 || w[15:8] == 8'h99 || w[15:8] == 8'h9B ||
        (w[15:10] == 6'b111111 && w[3] == 1'b0)) return 3'd2;
    if ((w[15:14] == 2'b10 && w[12] == 1'b0 && w[9] == 1'b0) || w[15:11] == 5'b10110 ||
        w == 16'h95C8 || w == 16'h95D8 ||
        (w[15:9] == 7'b1001000 && n inside {[0:2], [4:7], 9, 10, [12:15]})) return 3'd3;
    if ((w[15:14] == 2'b10 && w[12] == 1'b0 && w[9] == 1'b1) || w[15:11] == 5'b10111 ||
        (w[15:9] == 7'b1001001 && n inside {[0:2], 9, 10, [12:15]})) return 3'd4;
    if (w >= 16'h0001 && w <= 16'h00FF) return 3'd5;
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    m_rec_t h;
    h = (q.size() != 0) ? q[0] : last;
    chk({tag, "_vld"}, 64'(tr_vld), 64'(q.size() != 0));
    chk({tag, "_cnt"}, 64'(tr_cnt), 64'(q.size()));
    chk({tag, "_drp"}, 64'(tr_drp), 64'(drops));
    chk({tag, "_head"}, 64'({tr_adr, tr_ins, tr_ext, tr_len, tr_cls, tr_err}),
        64'({h.adr, h.ins, h.ext, h.len, h.cls, h.err}));
  endtask

  task automatic model_reset();
    q.delete();
    last = '{default: '0};
    pend = 0; p_adr = '0; p_ins = '0; drops = 0;
  endtask

  task automatic cycle(input bit v, input logic [15:0] a, input logic [15:0] w,
                       input bit fl, input bit rd, input string tag);
    m_rec_t r;
    bit do_push;
    @(negedge clk);
    rst = 0; if_vld = v; if_adr = a; if_ins = w; if_flush = fl; tr_rdy = rd;
    do_push = 0;
    r = '{default: '0};
    if (pend) begin
      if (fl) pend = 0;
      else if (v) begin
        r.adr = p_adr; r.ins = p_ins; r.ext = w; r.len = 1;
        r.cls = ref_cls(p_ins); r.err = (a != 16'(p_adr + 1));
        do_push = 1; pend = 0;
      end
    end else if (v) begin
      if (ref_two(w)) begin pend = 1; p_adr = a; p_ins = w; end
      else begin r.adr = a; r.ins = w; r.cls = ref_cls(w); do_push = 1; end
    end
    if (q.size() != 0 && rd) last = q.pop_front();
    if (do_push) begin
      if (q.size() < DEPTH) q.push_back(r);
      else if (drops < DMAX) drops++;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; if_vld = 0; if_flush = 0; tr_rdy = 0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all("rst");
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 16'h0, 16'h0, 0, 1, "drain");
  endtask

  logic [15:0] tw [5] = '{16'h940C, 16'h940E, 16'h9100, 16'h9300, 16'h95FD};
  logic [15:0] sw [14] = '{16'h9409, 16'h9508, 16'h95C8, 16'h99A3, 16'h2C01, 16'h0005,
                           16'hF3F1, 16'hFE07, 16'h8000, 16'h8208, 16'hB000, 16'hB800,
                           16'h0000, 16'h9104};

  initial begin
    logic [15:0] a, w;
    int r;
    model_reset();
    do_reset();
    do_reset();
    chk("reset_adr", 64'(tr_adr), 64'h0);
    chk("reset_len_cls_err", 64'({tr_len, tr_cls, tr_err}), 64'h0);

    cycle(1, 16'h0010, 16'h2C01, 0, 0, "mov");
    chk("mov_fields", 64'({tr_vld, tr_adr, tr_ins, tr_len, tr_cls}), 64'({1'b1, 16'h0010, 16'h2C01, 1'b0, 3'd0}));
    chk("mov_cnt", 64'(tr_cnt), 64'd1);
    drain();

    cycle(1, 16'h0020, 16'h940C, 0, 0, "jmp1");
    chk("jmp_pending", 64'(tr_vld), 64'd0);
    cycle(1, 16'h0021, 16'h1234, 0, 0, "jmp2");
    chk("jmp_rec", 64'({tr_ins, tr_ext, tr_len, tr_cls, tr_err}), 64'({16'h940C, 16'h1234, 1'b1, 3'd1, 1'b0}));
    chk("jmp_cnt", 64'(tr_cnt), 64'd1);
    drain();

    cycle(1, 16'h0030, 16'h9100, 0, 0, "lds1");
    cycle(1, 16'h0040, 16'h0100, 0, 0, "lds2");
    chk("lds_err_cls", 64'({tr_err, tr_cls}), 64'({1'b1, 3'd3}));
    drain();

    cycle(1, 16'h0050, 16'h9300, 0, 0, "sts1");
    cycle(1, 16'h0051, 16'hE0FF, 1, 0, "sts_flush");
    chk("flush_no_rec", 64'(tr_vld), 64'd0);
    cycle(1, 16'h0052, 16'h2C01, 0, 0, "after_flush");
    chk("after_flush_rec", 64'({tr_vld, tr_adr, tr_len}), 64'({1'b1, 16'h0052, 1'b0}));
    drain();

    for (int i = 0; i < 20; i++) cycle(1, 16'(16'h0100 + i), 16'h2C00, 0, 0, "fill");
    chk("full_cnt", 64'(tr_cnt), 64'd16);
    chk("full_drp", 64'(tr_drp), 64'd4);
    for (int i = 0; i < 24; i++) cycle(1, 16'(16'h0200 + i), 16'h0000, 0, 1, "stream");
    chk("stream_drp", 64'(tr_drp), 64'd4);
    for (int i = 0; i < 300; i++) cycle(1, 16'(16'h0300 + i), 16'h2C00, 0, 0, "sat");
    chk("sat_drp", 64'(tr_drp), 64'(DMAX));

    cycle(1, 16'h0060, 16'h940C, 0, 1, "pre_rst");
    do_reset();
    chk("midrst_out", 64'({tr_vld, tr_adr, tr_ins, tr_ext, tr_len, tr_cls, tr_err}), 64'h0);
    chk("midrst_cnt_drp", 64'({tr_cnt, tr_drp}), 64'h0);
    cycle(1, 16'h0061, 16'h0000, 0, 0, "post_rst");
    chk("post_rst_len", 64'({tr_vld, tr_len, tr_adr}), 64'({1'b1, 1'b0, 16'h0061}));
    drain();

    a = 16'h0400;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) w = tw[$urandom_range(0, 4)];
      else if (r < 6) w = sw[$urandom_range(0, 13)];
      else w = 16'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(a + 1);
      cycle($urandom_range(0, 9) < 8, a, w, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 5, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rp_8bit_trace.md
Name: rp_8bit_trace

Overview:
- Synthesizable instruction-trace collector for the rp_8bit core.
- Watches the instruction fetch stream and reassembles two-word instructions (lds, sts, jmp, call) into single records.
- Tags each record with an opcode class and buffers it in a parametrised FIFO for a trace port or testbench disassembler.
- Records that arrive while the FIFO is full are counted as drops.

Parameters:
- PAW, 16, program address width (word addresses).
- DEPTH, 16, FIFO depth in records; power of 2, at least 2.
- CW, 8, drop-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- if_vld  in  1  fetched word valid this cycle
- if_adr  in  PAW  word address of fetched word
- if_ins  in  16  fetched instruction word
- if_flush  in  1  discard a pending first word (branch taken, skip, interrupt)
- tr_vld  out  1  FIFO head valid
- tr_rdy  in  1  consumer accepts head
- tr_adr  out  PAW  address of first word
- tr_ins  out  16  first word
- tr_ext  out  16  second word; 0 when tr_len=0
- tr_len  out  1  0 = 16-bit instruction, 1 = 32-bit instruction
- tr_cls  out  3  opcode class
- tr_err  out  1  second word address was not first address + 1
- tr_cnt  out  $clog2(DEPTH)+1  FIFO occupancy
- tr_drp  out  CW  dropped-record count, saturating

Behaviour:
- One clock domain. Reset is synchronous, active-high.
- Reset values:
  - state = IDLE.
  - FIFO empty; tr_vld=0, tr_cnt=0, tr_drp=0.
  - tr_adr, tr_ins, tr_ext, tr_len, tr_cls, tr_err all 0.
- Reset mid-operation discards the pending word and all FIFO contents.
- Two-word detect, applied to if_ins in IDLE:
  - lds = 1001_000x_xxxx_0000.
  - sts = 1001_001x_xxxx_0000.
  - jmp/call = 1001_010x_xxxx_11xx.
- State machine IDLE / WAIT2:
  - IDLE, if_vld with a 16-bit word: push record {adr, ins, ext=0, len=0, err=0}; stay in IDLE.
  - IDLE, if_vld with a two-word first word: latch adr and ins; go to WAIT2; no push.
  - WAIT2, if_vld: push record {latched adr, latched ins, ext=if_ins, len=1, err=(if_adr != latched adr+1 mod 2^PAW)}; go to IDLE. The word is always consumed as the second word, even if it itself decodes as two-word.
  - WAIT2 with if_flush=1 (priority over if_vld): drop the pending word without a push and without a drop count; go to IDLE.
  - IDLE with if_flush=1: no effect; a simultaneous if_vld is processed normally.
- Class tr_cls, decoded from the first word:
  - 1 flow: rjmp, rcall, jmp, call, brbs/brbc (1111_0xxx), ijmp 0x9409, eijmp 0x9419, icall 0x9509, eicall 0x9519, ret 0x9508, reti 0x9518.
  - 2 skip: cpse (0001_00xx), sbic 1001_1001, sbis 1001_1011, sbrc/sbrs (1111_11xx_xxxx_0xxx).
  - 3 load: ld/ldd (10x0_xx0x), 1001_000x with low nibble 0000, 0001, 0010, 0100–0111, 1001, 1010, 1100–1111; in (1011_0); lpm 0x95C8; elpm 0x95D8.
  - 4 store: st/std (10x0_xx1x), 1001_001x with low nibble 0000, 0001, 0010, 1001, 1010, 1100–1111; out (1011_1).
  - 5 undefined: 0x0001–0x00FF.
  - 0 all others, including nop 0x0000.
- FIFO:
  - First-word-fall-through. A record pushed in cycle N is visible at the outputs with tr_vld=1 in cycle N+1.
  - Pop when tr_vld & tr_rdy.
  - Push while full with a simultaneous pop: accepted; occupancy unchanged.
  - Push while full with no pop: record discarded; tr_drp increments, saturating at 2^CW-1.
  - Pointers wrap modulo DEPTH.
  - tr_cnt reflects registered occupancy.
- Outputs are undefined-free while tr_vld=0: they hold the last head value or the reset value.

Test Plan:
- Reset, then feed adr 0x0010 ins 0x2C01 (mov r0,r1), no stall.
  → Next cycle tr_vld=1, tr_adr=0x0010, tr_ins=0x2C01, tr_len=0, tr_cls=0, tr_cnt=1.
- Feed adr 0x0020 ins 0x940C (jmp), then adr 0x0021 ins 0x1234.
  → Exactly one record: tr_ins=0x940C, tr_ext=0x1234, tr_len=1, tr_cls=1, tr_err=0.
- Feed 0x9100 (lds) at adr 0x0030, then 0x0100 at adr 0x0040.
  → Record with tr_err=1, tr_cls=3.
- Feed 0x9300 (sts) at adr 0x0050, assert if_flush next cycle together with an if_vld word 0xE0FF.
  → No record emitted; state back to IDLE; the following 16-bit word is recorded normally.
- With DEPTH=16 and tr_rdy=0, push 20 16-bit words.
  → tr_cnt=16, tr_drp=4. Then raise tr_rdy while pushing continuously: no further drops, addresses pop in order.
- With CW=2, 5 drops → tr_drp saturates at 3. Assert rst mid-WAIT2 → all outputs return to reset values the next cycle.
